// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_ADDR = 3'd1,
    S_IF_DATA = 3'd2,
    S_LS_ADDR = 3'd3,
    S_LS_DATA = 3'd4
  } state_t;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  // Bit 2 of the fetch address picks the 32-bit half of the 64-bit beat.
  function automatic logic [31:0] fetch_word(input logic hi,
                                             input logic [63:0] d);
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant decision between IFU and LSU with the LSU streak limiter.
module arb_pick #(
  parameter int LS_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic if_flush_i,
  input  logic ls_req_i,
  output logic grant_ls_o,
  output logic grant_if_o
);

  localparam int SW = $clog2(LS_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          under;

  assign under = streak_q < SW'(LS_STREAK);

  always_comb begin
    grant_ls_o = idle_i & ls_req_i & (~if_req_i | under);
    grant_if_o = idle_i & ~grant_ls_o & if_req_i & ~if_flush_i;
    streak_d   = streak_q;
    if (grant_if_o) begin
      streak_d = '0;
    end else if (grant_ls_o & if_req_i & under) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the core memory port between fetch and load/store,
// one outstanding transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              ifetch_en,
  input  logic              ls_req,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [31:0]       instr_q, instr_d;
  logic              iv_q, iv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              grant_ls, grant_if;

  arb_pick #(
    .LS_STREAK (LS_STREAK)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .idle_i     (state_q == S_IDLE),
    .if_req_i   (if_req),
    .if_flush_i (if_flush),
    .ls_req_i   (ls_req),
    .grant_ls_o (grant_ls),
    .grant_if_o (grant_if)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    instr_d = instr_q;
    iv_d    = 1'b0;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (grant_ls) begin
          state_d = S_LS_ADDR;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wen ? ls_wmask : 8'h00;
        end else if (grant_if) begin
          state_d = S_IF_ADDR;
          addr_d  = if_pc;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = 8'h00;
        end
      end
      S_IF_ADDR: begin
        if (if_flush) drop_d = 1'b1;
        if (mem_ready) state_d = S_IF_DATA;
      end
      S_IF_DATA: begin
        if (if_flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          // A redirect in the response cycle still kills the fetch.
          if (!drop_q && !if_flush) begin
            iv_d    = 1'b1;
            instr_d = fetch_word(addr_q[2], mem_rdata);
          end
        end
      end
      S_LS_ADDR: begin
        if (mem_ready) state_d = S_LS_DATA;
      end
      S_LS_DATA: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          rdata_d = mem_rdata;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= 8'h00;
      instr_q <= 32'h0;
      iv_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign mem_req     = (state_q == S_IF_ADDR) || (state_q == S_LS_ADDR);
  assign mem_wen     = wen_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign instr       = instr_q;
  assign instr_valid = iv_q;
  assign ifetch_en   = iv_q;
  assign ls_rdata    = rdata_q;
  assign ls_done     = done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LSK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [63:0] if_pc;
  logic [31:0] instr;
  logic        instr_valid, ifetch_en;
  logic        ls_req, ls_wen;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        ls_done;
  logic        mem_req, mem_wen;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready, mem_rvalid;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LS_STREAK(LSK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_pc(if_pc), .if_flush(if_flush),
    .instr(instr), .instr_valid(instr_valid), .ifetch_en(ifetch_en),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one outstanding access.
  bit          m_busy, m_acc, m_isls, m_drop, m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_streak;
  bit          e_iv, e_done, e_store;
  logic [31:0] e_instr;
  logic [63:0] e_rdata;

  // Bench-side agents.
  bit          auto_on, rnd_if, rnd_ls, rd_rand, lsu_active;
  int          rdy_pct, rv_pct, ls_pct, ls_left, ls_n;
  logic [63:0] rd_const, ls_base;
  string       glog;
  bit          prev_req;
  int          acc_cnt;
  logic [63:0] last_rdata;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act,
                         input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_isls = 0; m_drop = 0; m_wen = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_streak = 0;
    e_iv = 0; e_done = 0; e_store = 0; e_instr = '0; e_rdata = '0;
  endtask

  // Advance the model over one clock edge using the current inputs.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    e_iv = 0;
    e_done = 0;
    if (!m_busy) begin
      if (ls_req && (!if_req || m_streak < LSK)) begin
        m_busy = 1; m_acc = 0; m_isls = 1;
        m_addr = ls_addr; m_wen = ls_wen; m_wdata = ls_wdata;
        m_wmask = ls_wen ? ls_wmask : 8'h00;
        if (if_req) m_streak++;
      end else if (if_req && !if_flush) begin
        m_busy = 1; m_acc = 0; m_isls = 0; m_drop = 0;
        m_addr = if_pc; m_wen = 0; m_wdata = '0; m_wmask = 8'h00;
        m_streak = 0;
      end
    end else if (!m_acc) begin
      if (!m_isls && if_flush) m_drop = 1;
      if (mem_ready) m_acc = 1;
    end else begin
      if (!m_isls && if_flush) m_drop = 1;
      if (mem_rvalid) begin
        m_busy = 0;
        if (m_isls) begin
          e_done = 1;
          e_store = m_wen;
          e_rdata = mem_rdata;
        end else if (!m_drop) begin
          e_iv = 1;
          e_instr = m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end
        m_drop = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic er;
    er = m_busy && !m_acc;
    chk("mem_req", 64'(mem_req), 64'(er));
    if (er) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", 64'(mem_wen), 64'(m_wen));
      chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
      if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("instr_valid", 64'(instr_valid), 64'(e_iv));
    chk("ifetch_en", 64'(ifetch_en), 64'(e_iv));
    if (e_iv) chk("instr", 64'(instr), 64'(e_instr));
    chk("ls_done", 64'(ls_done), 64'(e_done));
    if (e_done && !e_store) chk("ls_rdata", ls_rdata, e_rdata);
    if (mem_req && !prev_req) begin
      if (mem_addr >= RESET_PC + 64'h1000) glog = {glog, "L"};
      else glog = {glog, "I"};
    end
    prev_req = mem_req;
    if (mem_req && mem_ready) acc_cnt++;
    if (ls_done) last_rdata = ls_rdata;
  endtask

  task automatic start_ls();
    lsu_active = 1;
    ls_left--;
    ls_req = 1;
    if (rnd_ls) begin
      ls_wen = 1'($urandom_range(1));
      ls_addr = {$urandom, $urandom};
    end else begin
      ls_wen = 0;
      ls_addr = ls_base + 64'(ls_n * 8);
    end
    ls_wdata = {$urandom, $urandom};
    ls_wmask = 8'($urandom);
    ls_n++;
  endtask

  task automatic drive_auto();
    if (!auto_on) return;
    if (lsu_active && e_done) begin
      lsu_active = 0;
      ls_req = 0;
    end
    if (!lsu_active && ls_left > 0 && $urandom_range(99) < ls_pct)
      start_ls();
    mem_ready  = $urandom_range(99) < rdy_pct;
    mem_rvalid = $urandom_range(99) < rv_pct;
    mem_rdata  = rd_rand ? {$urandom, $urandom} : rd_const;
    if (rnd_if) begin
      if_req   = $urandom_range(99) < 60;
      if_pc    = {$urandom, $urandom} & ~64'h3;
      if_flush = $urandom_range(99) < 10;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    drive_auto();
  endtask

  task automatic quiesce(input string nm);
    for (int i = 0; i < 200 && (m_busy || lsu_active); i++) tick();
    chk({nm, "_idle"}, 64'(m_busy || lsu_active), 64'd0);
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({nm, "_mem_wen"}, 64'(mem_wen), 64'd0);
    chk({nm, "_mem_addr"}, mem_addr, 64'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({nm, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
    chk({nm, "_instr"}, 64'(instr), 64'd0);
    chk({nm, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({nm, "_ifetch_en"}, 64'(ifetch_en), 64'd0);
    chk({nm, "_ls_rdata"}, ls_rdata, 64'd0);
    chk({nm, "_ls_done"}, 64'(ls_done), 64'd0);
  endtask

  task automatic manual_idle_inputs();
    auto_on = 0;
    if_req = 0; if_flush = 0; if_pc = RESET_PC;
    ls_req = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  initial begin
    manual_idle_inputs();
    rnd_if = 0; rnd_ls = 0; rd_rand = 0; lsu_active = 0;
    rdy_pct = 100; rv_pct = 100; ls_pct = 100; ls_left = 0; ls_n = 0;
    rd_const = '0; ls_base = RESET_PC + 64'h1000;
    glog = ""; prev_req = 0; acc_cnt = 0; last_rdata = '0;
    rst = 1;
    model_reset();
    repeat (2) tick();
    zero_check("reset");
    rst = 0;

    // Single fetch from an upper-half address.
    if_req = 1; if_pc = RESET_PC + 64'h4;
    mem_rdata = {32'h0050_0093, NOP};
    tick();
    if_req = 0;
    chk("fetch_req", 64'(mem_req), 64'd1);
    chk("fetch_addr", mem_addr, 64'h8000_0004);
    acc_cnt = 0;
    mem_ready = 1;
    tick();
    mem_ready = 0; mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
    chk("fetch_valid", 64'(instr_valid), 64'd1);
    chk("fetch_en", 64'(ifetch_en), 64'd1);
    chk("fetch_instr", 64'(instr), 64'h0050_0093);
    chk("model_instr", 64'(e_instr), 64'h0050_0093);
    chk("fetch_accepts", 64'(acc_cnt), 64'd1);
    tick();
    chk("fetch_pulse_end", 64'(instr_valid), 64'd0);

    // Simultaneous fetch and load: load wins, fetch follows.
    auto_on = 1; rd_const = 64'h1122_3344_5566_7788;
    rdy_pct = 100; rv_pct = 100; ls_pct = 100; ls_n = 0;
    ls_left = 1;
    if_req = 1; if_pc = RESET_PC + 64'h200;
    glog = "";
    start_ls();
    for (int i = 0; i < 50 && glog.len() < 2; i++) tick();
    if_req = 0;
    quiesce("simul");
    chk_str("simul_order", glog, "LI");
    chk("simul_rdata", last_rdata, 64'h1122_3344_5566_7788);

    // Starvation limiter with six back-to-back loads.
    glog = ""; ls_n = 0; ls_left = 6;
    if_req = 1; if_pc = RESET_PC + 64'h100;
    start_ls();
    for (int i = 0; i < 200 && glog.len() < 7; i++) tick();
    if_req = 0;
    quiesce("starve");
    chk_str("starve_order", glog, "LLLLILL");

    // Redirect while the fetch is in its data phase.
    manual_idle_inputs();
    mem_rdata = 64'h00A0_0113_00B0_0193;
    if_req = 1; if_pc = RESET_PC + 64'h300;
    tick();
    mem_ready = 1;
    tick();
    mem_ready = 0; if_flush = 1; if_pc = RESET_PC + 64'h400;
    tick();
    if_flush = 0; mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
    chk("flush_no_valid", 64'(instr_valid), 64'd0);
    tick();
    if_req = 0;
    chk("flush_refetch_req", 64'(mem_req), 64'd1);
    chk("flush_refetch_addr", mem_addr, 64'h8000_0400);
    mem_ready = 1;
    tick();
    mem_ready = 0; mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
    chk("refetch_valid", 64'(instr_valid), 64'd1);
    chk("refetch_instr", 64'(instr), 64'h00B0_0193);

    // Store held until accepted.
    manual_idle_inputs();
    ls_req = 1; ls_wen = 1; ls_addr = RESET_PC + 64'h2000;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    tick();
    chk("store_wen", 64'(mem_wen), 64'd1);
    chk("store_wmask", 64'(mem_wmask), 64'h0F);
    chk("store_wdata", mem_wdata, 64'hDEAD_BEEF);
    tick();
    chk("store_hold_req", 64'(mem_req), 64'd1);
    chk("store_hold_wmask", 64'(mem_wmask), 64'h0F);
    mem_ready = 1;
    tick();
    mem_ready = 0; mem_rvalid = 1;
    tick();
    mem_rvalid = 0; ls_req = 0;
    chk("store_done", 64'(ls_done), 64'd1);
    tick();
    chk("store_done_end", 64'(ls_done), 64'd0);

    // Reset during a load's data phase; stale response must vanish.
    manual_idle_inputs();
    ls_req = 1; ls_addr = RESET_PC + 64'h3000; mem_ready = 1;
    tick();
    tick();
    mem_ready = 0; ls_req = 0;
    rst = 1;
    model_reset();
    #2;
    zero_check("rst_async");
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
    tick();
    mem_rvalid = 0;
    tick();
    zero_check("rst_stale");

    // Randomized traffic against the model.
    auto_on = 1; rnd_if = 1; rnd_ls = 1; rd_rand = 1;
    rdy_pct = 50; rv_pct = 40; ls_pct = 30; ls_left = 1000000;
    for (int i = 0; i < 3000; i++) tick();
    rnd_if = 0; if_req = 0; if_flush = 0; ls_left = 0;
    quiesce("random");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core-side memory port between instruction fetch (IFU) and load/store (LSU).
- Generates the IFU fetch strobes (instr, instr_valid, ifetch_en) and the LSU completion strobe (ls_done).
- Sits between the pipeline front/back ends and the memory/bus bridge.
- One transaction is outstanding at a time; a redirect discards an in-flight fetch.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, memory data width (fixed at 64)
LS_STREAK, 4, maximum consecutive LSU grants while a fetch is pending before IFU is forced a grant

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
if_req  in  1  IFU wants a fetch at if_pc
if_pc  in  ADDR_W  fetch address; sampled at grant
if_flush  in  1  redirect (jump_en); in-flight fetch result is dropped
instr  out  32  fetched instruction
instr_valid  out  1  one-cycle pulse; instr valid
ifetch_en  out  1  one-cycle pulse, identical to instr_valid; advances pc
ls_req  in  1  LSU request; held high until ls_done
ls_wen  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_wmask  in  8  byte-lane mask for stores
ls_rdata  out  DATA_W  load data; valid with ls_done
ls_done  out  1  one-cycle completion pulse for load or store
mem_req  out  1  memory request valid
mem_wen  out  1  write enable
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_wmask  out  8  write mask; 0 for reads
mem_ready  in  1  request accepted this cycle
mem_rvalid  in  1  response valid (reads and write acks)
mem_rdata  in  DATA_W  read data

Behaviour:
- Reset state (asynchronous, during rst): state IDLE, drop=0, streak=0, all outputs 0.
- FSM states: IDLE, IF_ADDR, IF_DATA, LS_ADDR, LS_DATA.
- IDLE grant rule, applied when some request is pending:
  - Grant LS if ls_req and (!if_req or streak<LS_STREAK).
  - Otherwise grant IF if if_req and !if_flush.
  - The granted request's address, data and mask are latched into request registers.
- Counter streak: incremented on each LS grant taken while if_req=1; cleared on any IF grant; saturates at LS_STREAK.
- IF_ADDR / LS_ADDR:
  - mem_req=1 with address/wen/wdata/wmask held stable from the latched registers.
  - The request may not be withdrawn.
  - Move to the matching _DATA state in the cycle mem_ready=1.
- Accept and response may not share a cycle. mem_rvalid is ignored outside the _DATA states, including in the accept cycle.
- IF_DATA:
  - On mem_rvalid, go to IDLE.
  - If !drop and !if_flush that cycle, register instr = latched_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0] and pulse instr_valid and ifetch_en the next cycle.
- LS_DATA:
  - On mem_rvalid, go to IDLE.
  - Register ls_rdata = mem_rdata (stores: don't-care) and pulse ls_done the next cycle.
- drop flag:
  - Set when if_flush=1 in IF_ADDR or IF_DATA.
  - Cleared on return to IDLE.
  - if_flush in IDLE or the LS states has no effect.
- Latency, no stalls: grant cycle G, mem_req visible from G+1, accept at A≥G+1, rvalid at R≥A+1, strobe at R+1.
- Back-to-back grants: the IDLE cycle after a response may grant immediately.
- Async rst mid-transaction: FSM returns to IDLE. A later stale mem_rvalid is ignored and produces no strobe.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=0, IF_ADDR, IF_DATA, LS_ADDR, LS_DATA).
  - NOP constant 32'h13.
  - Reset-PC constant 64'h80000000.
- Sub-module arb_pick: combinational grant decision plus the streak counter.
- The remaining logic stays in a single file.

Test Plan:
- Single fetch: if_req=1, if_pc=0x80000004, mem_rdata=0x00500093_00000013, ready 1 cycle later, rvalid 2 cycles later -> instr=0x00500093, instr_valid and ifetch_en 1-cycle pulse; mem_req seen for exactly one accept.
- Simultaneous if_req and ls_req (load 0x80001000): LS granted first, ls_done with ls_rdata=mem_rdata; the fetch follows immediately after.
- Starvation: ls_req held for 6 back-to-back loads with if_req=1 and LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS,LS.
- Flush in IF_DATA: if_flush pulses 1 cycle before rvalid -> no instr_valid; the next fetch uses the new if_pc.
- Store: ls_wen=1, wmask=0x0F, wdata=0xDEADBEEF -> mem_wen=1 and mem_wmask=0x0F held until ready; ls_done pulses after the ack.
- rst asserted in LS_DATA, rvalid arrives after release -> no ls_done; state IDLE; all outputs 0.
